// File: rtl/axi_master_bridge_pkg.sv
// Shared AXI constants and the master-bridge state encoding.
// Optional feature macro used by the bridge: AXI_MASTER_ERR_CHECK_EN.
package axi_master_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAw,
    StW,
    StB
  } master_state_e;

endpackage

// File: rtl/axi_master_bridge_beat_counter.sv
// 8-bit AXI beat counter: clear, increment, and compare against the burst length.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_clear   - zero the count (takes priority over i_inc)
//   i_inc     - advance the count by one beat
//   i_len     - burst length in AXI encoding (beats-1)
//   o_count   - current beat index
//   o_last    - current beat is the final one of the burst
module axi_master_bridge_beat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_inc,
  input  logic [7:0] i_len,
  output logic [7:0] o_count,
  output logic       o_last
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_inc) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == i_len);

endmodule

// File: rtl/axi_master_bridge.sv
// AXI4 master bridge: turns a single-outstanding CPU memory request into one AXI4 INCR burst.
// Read beats stream back on rsp_*; write beats are pulled from wr_*; write completion is one
// rsp beat with rsp_last=1.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_* (valid/ready/write/addr/len/size)  request handshake, accepted only when idle
//   wr_* (valid/ready/data/strb)     upstream write-beat stream
//   rsp_* (valid/ready/data/last/err)  response stream back to the CPU side
//   o_axi_master_* / i_axi_master_*  AXI4 AR, R, AW, W, B channels
// Macro AXI_MASTER_ERR_CHECK_EN: when defined, rsp_err flags non-OKAY responses and ID
// mismatches; otherwise rsp_err is 0 and the resp/ID inputs are ignored.
module axi_master_bridge
  import axi_master_bridge_pkg::*;
#(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 64,
  parameter int unsigned IDWIDTH = 4,
  parameter int unsigned AXI_ID  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [7:0]          req_len,
  input  logic [2:0]          req_size,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic [DWIDTH/8-1:0] wr_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DWIDTH-1:0]   rsp_data,
  output logic                rsp_last,
  output logic                rsp_err,
  output logic                o_axi_master_arvalid,
  output logic [AWIDTH-1:0]   o_axi_master_araddr,
  output logic [IDWIDTH-1:0]  o_axi_master_arid,
  output logic [7:0]          o_axi_master_arlen,
  output logic [2:0]          o_axi_master_arsize,
  output logic [1:0]          o_axi_master_arburst,
  input  logic                i_axi_master_arready,
  input  logic                i_axi_master_rvalid,
  input  logic                i_axi_master_rlast,
  input  logic [1:0]          i_axi_master_rresp,
  input  logic [DWIDTH-1:0]   i_axi_master_rdata,
  input  logic [IDWIDTH-1:0]  i_axi_master_rid,
  output logic                o_axi_master_rready,
  output logic                o_axi_master_awvalid,
  output logic [AWIDTH-1:0]   o_axi_master_awaddr,
  output logic [IDWIDTH-1:0]  o_axi_master_awid,
  output logic [7:0]          o_axi_master_awlen,
  output logic [2:0]          o_axi_master_awsize,
  output logic [1:0]          o_axi_master_awburst,
  input  logic                i_axi_master_awready,
  output logic                o_axi_master_wvalid,
  output logic [DWIDTH-1:0]   o_axi_master_wdata,
  output logic [DWIDTH/8-1:0] o_axi_master_wstrb,
  output logic                o_axi_master_wlast,
  input  logic                i_axi_master_wready,
  input  logic                i_axi_master_bvalid,
  input  logic [1:0]          i_axi_master_bresp,
  input  logic [IDWIDTH-1:0]  i_axi_master_bid,
  output logic                o_axi_master_bready
);

  localparam logic [IDWIDTH-1:0] LP_ID = IDWIDTH'(AXI_ID);

  master_state_e r_state, w_state_d;

  // Request buffer, loaded only on the request handshake so ar*/aw* stay stable.
  logic [AWIDTH-1:0] r_req_addr;
  logic [7:0]        r_req_len;
  logic [2:0]        r_req_size;
  logic              r_req_write;

  logic w_req_hs, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs;
  logic [7:0] w_wcnt, w_rcnt;
  logic       w_wcnt_last, w_rcnt_last;

  assign w_req_hs = req_valid & req_ready;
  assign w_ar_hs  = o_axi_master_arvalid & i_axi_master_arready;
  assign w_r_hs   = i_axi_master_rvalid & o_axi_master_rready;
  assign w_aw_hs  = o_axi_master_awvalid & i_axi_master_awready;
  assign w_w_hs   = o_axi_master_wvalid & i_axi_master_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_req_addr  <= '0;
      r_req_len   <= 8'd0;
      r_req_size  <= 3'd0;
      r_req_write <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_req_hs) begin
        r_req_addr  <= req_addr;
        r_req_len   <= req_len;
        r_req_size  <= req_size;
        r_req_write <= req_write;
      end
    end
  end

  axi_master_bridge_beat_counter u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_aw_hs),
    .i_inc   (w_w_hs),
    .i_len   (r_req_len),
    .o_count (w_wcnt),
    .o_last  (w_wcnt_last)
  );

  // Read beats are tracked for visibility only; the burst ends on the slave's rlast.
  axi_master_bridge_beat_counter u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_ar_hs),
    .i_inc   (w_r_hs),
    .i_len   (r_req_len),
    .o_count (w_rcnt),
    .o_last  (w_rcnt_last)
  );

  assign o_axi_master_araddr  = r_req_addr;
  assign o_axi_master_arid    = LP_ID;
  assign o_axi_master_arlen   = r_req_len;
  assign o_axi_master_arsize  = r_req_size;
  assign o_axi_master_arburst = AXI_BURST_INCR;
  assign o_axi_master_awaddr  = r_req_addr;
  assign o_axi_master_awid    = LP_ID;
  assign o_axi_master_awlen   = r_req_len;
  assign o_axi_master_awsize  = r_req_size;
  assign o_axi_master_awburst = AXI_BURST_INCR;

  // Every handshake output is forced low while rst is high so a mid-burst reset
  // issues or consumes no further beats, even in the reset cycle itself.
  always_comb begin
    w_state_d            = r_state;
    req_ready            = 1'b0;
    wr_ready             = 1'b0;
    rsp_valid            = 1'b0;
    rsp_data             = '0;
    rsp_last             = 1'b0;
    o_axi_master_arvalid = 1'b0;
    o_axi_master_rready  = 1'b0;
    o_axi_master_awvalid = 1'b0;
    o_axi_master_wvalid  = 1'b0;
    o_axi_master_wdata   = '0;
    o_axi_master_wstrb   = '0;
    o_axi_master_wlast   = 1'b0;
    o_axi_master_bready  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        StIdle: begin
          req_ready = 1'b1;
          if (req_valid) w_state_d = req_write ? StAw : StAr;
        end
        StAr: begin
          o_axi_master_arvalid = 1'b1;
          if (i_axi_master_arready) w_state_d = StR;
        end
        StR: begin
          o_axi_master_rready = rsp_ready;
          rsp_valid           = i_axi_master_rvalid;
          rsp_data            = i_axi_master_rdata;
          rsp_last            = i_axi_master_rlast;
          if (i_axi_master_rvalid && rsp_ready && i_axi_master_rlast) w_state_d = StIdle;
        end
        StAw: begin
          o_axi_master_awvalid = 1'b1;
          if (i_axi_master_awready) w_state_d = StW;
        end
        StW: begin
          o_axi_master_wvalid = wr_valid;
          wr_ready            = i_axi_master_wready;
          o_axi_master_wdata  = wr_data;
          o_axi_master_wstrb  = wr_strb;
          o_axi_master_wlast  = w_wcnt_last;
          if (wr_valid && i_axi_master_wready && w_wcnt_last) w_state_d = StB;
        end
        StB: begin
          o_axi_master_bready = rsp_ready;
          rsp_valid           = i_axi_master_bvalid;
          rsp_last            = 1'b1;
          if (i_axi_master_bvalid && rsp_ready) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

`ifdef AXI_MASTER_ERR_CHECK_EN
  always_comb begin
    rsp_err = 1'b0;
    if (rsp_valid) begin
      if (r_state == StR) begin
        rsp_err = (i_axi_master_rresp != AXI_RESP_OKAY) || (i_axi_master_rid != LP_ID);
      end else begin
        rsp_err = (i_axi_master_bresp != AXI_RESP_OKAY) || (i_axi_master_bid != LP_ID);
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{w_wcnt, w_rcnt, w_rcnt_last, r_req_write};
`else
  assign rsp_err = 1'b0;

  logic w_unused;
  assign w_unused = ^{w_wcnt, w_rcnt, w_rcnt_last, r_req_write, i_axi_master_rresp,
                      i_axi_master_rid, i_axi_master_bresp, i_axi_master_bid};
`endif

endmodule

// File: tb/tb_axi_master_bridge.sv
module tb_axi_master_bridge;
  import axi_master_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [2:0]  req_size = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_last, rsp_err;
  logic [63:0] rsp_data;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, rready;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, rid = '0, bid = '0;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp = '0, bresp = '0;
  logic [63:0] rdata = '0, wdata;
  logic        awvalid, awready = 1'b0, wvalid, wlast, wready = 1'b0;
  logic        bvalid = 1'b0, bready;

  always #5 clk = ~clk;

  axi_master_bridge #(.AWIDTH(32), .DWIDTH(64), .IDWIDTH(4), .AXI_ID(0)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .o_axi_master_arvalid(arvalid), .o_axi_master_araddr(araddr), .o_axi_master_arid(arid),
    .o_axi_master_arlen(arlen), .o_axi_master_arsize(arsize), .o_axi_master_arburst(arburst),
    .i_axi_master_arready(arready),
    .i_axi_master_rvalid(rvalid), .i_axi_master_rlast(rlast), .i_axi_master_rresp(rresp),
    .i_axi_master_rdata(rdata), .i_axi_master_rid(rid), .o_axi_master_rready(rready),
    .o_axi_master_awvalid(awvalid), .o_axi_master_awaddr(awaddr), .o_axi_master_awid(awid),
    .o_axi_master_awlen(awlen), .o_axi_master_awsize(awsize), .o_axi_master_awburst(awburst),
    .i_axi_master_awready(awready),
    .o_axi_master_wvalid(wvalid), .o_axi_master_wdata(wdata), .o_axi_master_wstrb(wstrb),
    .o_axi_master_wlast(wlast), .i_axi_master_wready(wready),
    .i_axi_master_bvalid(bvalid), .i_axi_master_bresp(bresp), .i_axi_master_bid(bid),
    .o_axi_master_bready(bready)
  );

  typedef struct {logic [63:0] data; logic last; logic err;} rsp_t;
  typedef struct {logic [63:0] data; logic [7:0] strb; logic last;} wbeat_t;

  rsp_t   exp_rsp[$];
  wbeat_t exp_w[$];
  logic [31:0] exp_a;
  logic [7:0]  exp_len;
  logic [2:0]  exp_size;
  int errors = 0, checks = 0;
  int rsp_cnt = 0, rsp_last_cnt = 0, rsp_err_cnt = 0, w_seen = 0;
  logic [63:0] last_rsp_data = '0;
  logic w_allowed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_pat(input logic [31:0] a, input int i);
    return {32'hCAFE_0000 + 32'(i), a + 32'(i) * 32'd8};
  endfunction

  function automatic logic exp_err(input logic [1:0] resp);
`ifdef AXI_MASTER_ERR_CHECK_EN
    return resp != AXI_RESP_OKAY;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every handshake on AR/AW/W/rsp is checked against the expectation queues.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      w_allowed = 1'b0;
    end else begin
      if (arvalid && arready) begin
        chk("ar_addr", araddr, exp_a);
        chk("ar_len", arlen, exp_len);
        chk("ar_size", arsize, exp_size);
        chk("ar_burst", arburst, 2'b01);
        chk("ar_id", arid, 4'd0);
      end
      if (wvalid) chk("w_gate", w_allowed, 1'b1);
      if (awvalid && awready) begin
        chk("aw_addr", awaddr, exp_a);
        chk("aw_len", awlen, exp_len);
        chk("aw_size", awsize, exp_size);
        chk("aw_burst", awburst, 2'b01);
        chk("aw_id", awid, 4'd0);
        w_allowed = 1'b1;
      end
      if (wvalid && wready) begin
        w_seen++;
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_extra: unexpected write beat data 0x%0h", wdata);
        end else begin
          wbeat_t e;
          e = exp_w.pop_front();
          chk("w_data", wdata, e.data);
          chk("w_strb", wstrb, e.strb);
          chk("w_last", wlast, e.last);
        end
        if (wlast) w_allowed = 1'b0;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (rsp_last) rsp_last_cnt++;
        if (rsp_err) rsp_err_cnt++;
        last_rsp_data = rsp_data;
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_extra: unexpected rsp beat data 0x%0h", rsp_data);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_last", rsp_last, e.last);
          chk("rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_arvalid"}, arvalid, 1'b0);
    chk({tag, "_awvalid"}, awvalid, 1'b0);
    chk({tag, "_wvalid"}, wvalid, 1'b0);
    chk({tag, "_rready"}, rready, 1'b0);
    chk({tag, "_bready"}, bready, 1'b0);
    chk({tag, "_wr_ready"}, wr_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
  endtask

  task automatic issue_req(input logic wr, input logic [31:0] a, input logic [7:0] len);
    exp_a = a; exp_len = len; exp_size = AXI_SIZE_8B;
    rsp_cnt = 0; rsp_last_cnt = 0; rsp_err_cnt = 0; w_seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len; req_size = AXI_SIZE_8B;
    @(negedge clk);
    chk("req_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_len = 8'hFF;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input int ar_stall,
                         input int stall_beat, input int err_beat);
    for (int i = 0; i <= int'(len); i++) begin
      rsp_t e;
      e.data = rd_pat(a, i);
      e.last = (i == int'(len));
      e.err  = exp_err((i == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
      exp_rsp.push_back(e);
    end
    issue_req(1'b0, a, len);
    for (int k = 0; k < ar_stall; k++) begin
      @(negedge clk);
      chk("ar_stall_valid", arvalid, 1'b1);
      chk("ar_stall_addr", araddr, a);
      chk("ar_stall_req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    arready = 1'b1;
    @(negedge clk);
    chk("ar_valid", arvalid, 1'b1);
    @(posedge clk); #1;
    arready = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      rvalid = 1'b1; rdata = rd_pat(a, i); rlast = (i == int'(len)); rid = 4'd0;
      rresp = (i == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      if (i == stall_beat) begin
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("r_stall_rready", rready, 1'b0);
          chk("r_stall_rsp_valid", rsp_valid, 1'b1);
          @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk("r_rready", rready, 1'b1);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = AXI_RESP_OKAY; rsp_ready = 1'b0;
    @(negedge clk);
    chk("rd_done_idle", req_ready, 1'b1);
    chk("rd_queue_empty", exp_rsp.size(), 0);
    chk("rd_beats", rsp_cnt, int'(len) + 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input int abort_after,
                          input logic [63:0] d0, input logic [7:0] strb);
    for (int i = 0; i <= int'(len); i++) begin
      wbeat_t e;
      e.data = d0 + 64'(i); e.strb = strb; e.last = (i == int'(len));
      exp_w.push_back(e);
    end
    if (abort_after < 0) begin
      rsp_t r;
      r.data = '0; r.last = 1'b1; r.err = 1'b0;
      exp_rsp.push_back(r);
    end
    issue_req(1'b1, a, len);
    wr_valid = 1'b1; wr_data = d0; wr_strb = strb; wready = 1'b1;
    @(negedge clk);
    chk("w_before_aw", wvalid, 1'b0);
    chk("wr_ready_before_aw", wr_ready, 1'b0);
    chk("aw_valid", awvalid, 1'b1);
    @(posedge clk); #1;
    awready = 1'b1;
    @(negedge clk);
    chk("aw_valid_hs", awvalid, 1'b1);
    @(posedge clk); #1;
    awready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wr_data = d0 + 64'(i);
      @(negedge clk);
      chk("w_valid", wvalid, 1'b1);
      @(posedge clk); #1;
      if (i + 1 == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_wvalid", wvalid, 1'b0);
        chk("rst_cycle_wr_ready", wr_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        chk("abort_w_seen", w_seen, abort_after);
        @(posedge clk); #1;
        wr_valid = 1'b0; wready = 1'b0;
        @(negedge clk);
        chk("abort_no_more_w", w_seen, abort_after);
        exp_w.delete();
        return;
      end
    end
    wr_valid = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = AXI_RESP_OKAY; bid = 4'd0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("b_bready", bready, 1'b1);
    @(posedge clk); #1;
    bvalid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    chk("wr_done_idle", req_ready, 1'b1);
    chk("wr_w_empty", exp_w.size(), 0);
    chk("wr_rsp_empty", exp_rsp.size(), 0);
    chk("wr_beats", w_seen, int'(len) + 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_last", rsp_last, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);

    // Basic 4-beat read.
    do_read(32'h8000_0000, 8'd3, 0, -1, -1);
    chk("t1_beats", rsp_cnt, 4);
    chk("t1_lasts", rsp_last_cnt, 1);
    chk("t1_final_data", last_rsp_data, 64'hCAFE_0003_8000_0018);

    // Single-beat write.
    do_write(32'h8000_0100, 8'd0, -1, 64'h1122_3344_5566_7788, 8'h0F);
    chk("t2_rsp_cnt", rsp_cnt, 1);
    chk("t2_rsp_last", rsp_last_cnt, 1);
    chk("t2_rsp_data", last_rsp_data, 64'd0);

    // arready held low for 5 cycles.
    do_read(32'h8000_0200, 8'd1, 5, -1, -1);

    // rsp_ready backpressure mid-burst, 8 beats.
    do_read(32'h8000_1000, 8'd7, 0, 3, -1);
    chk("t4_beats", rsp_cnt, 8);
    chk("t4_final_data", last_rsp_data, 64'hCAFE_0007_8000_1038);

    // Reset after 2 of 4 write beats, then a clean read.
    do_write(32'h8000_2000, 8'd3, 2, 64'hA5A5_0000_0000_0000, 8'hFF);
    do_read(32'h8000_3000, 8'd2, 1, -1, -1);
    chk("t5_recover_beats", rsp_cnt, 3);

    // Slave error on the first of two beats.
    do_read(32'h8000_4000, 8'd1, 0, -1, 0);
`ifdef AXI_MASTER_ERR_CHECK_EN
    chk("t6_err_cnt", rsp_err_cnt, 1);
`else
    chk("t6_err_cnt", rsp_err_cnt, 0);
`endif

    // Stray rvalid/bvalid while idle produce no response.
    @(posedge clk); #1;
    rvalid = 1'b1; rlast = 1'b1; bvalid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("stray_rsp_valid", rsp_valid, 1'b0);
    chk("stray_rready", rready, 1'b0);
    chk("stray_bready", bready, 1'b0);
    @(posedge clk); #1;
    rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0; rsp_ready = 1'b0;

    // Multi-beat write to exercise wlast from the counter.
    do_write(32'h8000_5000, 8'd2, -1, 64'h0BAD_F00D_0000_0010, 8'hC3);

    @(negedge clk);
    check_idle("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
